pkt_tx: RTL and testbench

- Packet transmitter and header serializer: the sending end of the 32-bit packet word stream that the egress header parser consumes.
- Takes one packet request (dest port, src port, payload length), emits 6 header words then `len` payload words on a valid/ready stream.
- Sits between software/traffic-generator registers and the switch ingress path.
- Used as the on-chip traffic source for switch bring-up and latency measurement.

---
 rtl/pkt_tx_pkg.sv | 55 +++++
 rtl/pkt_tx.sv | 158 +++++++++++++++
 tb/tb_pkt_tx.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_tx_pkg.sv
// Shared definitions for the packet transmitter: stream width, header field
// positions, FSM state encoding and word packing helpers.
package pkt_tx_pkg;

  localparam int BLOCK_SIZE = 32;

  localparam int LEN_HI  = 29;
  localparam int LEN_LO  = 24;
  localparam int PORT_HI = 9;
  localparam int PORT_LO = 8;
  localparam int SEQ_HI  = 31;
  localparam int SEQ_LO  = 16;
  localparam int IDX_HI  = 5;
  localparam int IDX_LO  = 0;

  localparam int HDR_WORDS = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_HDR4,
    ST_HDR5,
    ST_PAYLOAD,
    ST_GAP
  } packet_tx_state_t;

  function automatic logic [BLOCK_SIZE-1:0] pack_hdr0(input logic [5:0] len,
                                                      input logic [1:0] dest);
    logic [BLOCK_SIZE-1:0] w;
    w                  = '0;
    w[LEN_HI:LEN_LO]   = len;
    w[PORT_HI:PORT_LO] = dest;
    return w;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] pack_port(input logic [1:0] port);
    logic [BLOCK_SIZE-1:0] w;
    w                  = '0;
    w[PORT_HI:PORT_LO] = port;
    return w;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] pack_payload(input logic [15:0] seq,
                                                         input logic [5:0]  idx);
    logic [BLOCK_SIZE-1:0] w;
    w                = '0;
    w[SEQ_HI:SEQ_LO] = seq;
    w[IDX_HI:IDX_LO] = idx;
    return w;
  endfunction

endpackage

// File: rtl/pkt_tx.sv
// Packet transmitter: accepts one request, then serialises six header words
// and len payload words onto a valid/ready stream, followed by an idle gap.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// HDR0    | len/dest word presented, sop=1
// HDR1    | dest MAC high half (reserved, zero)
// HDR2    | src port word
// HDR3    | src MAC high half (reserved, zero)
// HDR4    | t_start timestamp captured at accept
// HDR5    | timestamp frozen when HDR4 transferred; eop if len=0
// PAYLOAD | payload words {seq, index}; eop on the last
// GAP     | tx_valid low for GAP_CYCLES cycles before returning to IDLE
module pkt_tx
  import pkt_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int BLOCK_SIZE = pkt_tx_pkg::BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_dest,
  input  logic [1:0]            req_src,
  input  logic [5:0]            req_len,
  input  logic [31:0]           timer,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [BLOCK_SIZE-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic [31:0]           pkt_count
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  packet_tx_state_t state;
  logic [1:0]       dest_r;
  logic [1:0]       src_r;
  logic [5:0]       len_r;
  logic [31:0]      t_start;
  logic [5:0]       idx;
  logic [15:0]      seq;
  logic [GAP_W-1:0] gap_cnt;
  logic             xfer;

  assign xfer = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= '0;
      seq       <= '0;
      dest_r    <= '0;
      src_r     <= '0;
      len_r     <= '0;
      t_start   <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            dest_r    <= req_dest;
            src_r     <= req_src;
            len_r     <= req_len;
            t_start   <= timer;
            state     <= ST_HDR0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tx_valid  <= 1'b1;
            tx_data   <= pack_hdr0(req_len, req_dest);
            tx_sop    <= 1'b1;
            tx_eop    <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_HDR0: if (xfer) begin
          state   <= ST_HDR1;
          tx_data <= '0;
          tx_sop  <= 1'b0;
        end
        ST_HDR1: if (xfer) begin
          state   <= ST_HDR2;
          tx_data <= pack_port(src_r);
        end
        ST_HDR2: if (xfer) begin
          state   <= ST_HDR3;
          tx_data <= '0;
        end
        ST_HDR3: if (xfer) begin
          state   <= ST_HDR4;
          tx_data <= t_start;
        end
        // The HDR5 stamp is sampled once here and held through any stall.
        ST_HDR4: if (xfer) begin
          state   <= ST_HDR5;
          tx_data <= timer;
          tx_eop  <= (len_r == 6'd0);
        end
        ST_HDR5: if (xfer && (len_r != 6'd0)) begin
          state   <= ST_PAYLOAD;
          idx     <= 6'd0;
          tx_data <= pack_payload(seq, 6'd0);
          tx_eop  <= (len_r == 6'd1);
        end
        ST_PAYLOAD: if (xfer && !tx_eop) begin
          idx     <= idx + 6'd1;
          tx_data <= pack_payload(seq, idx + 6'd1);
          tx_eop  <= ((idx + 6'd1) == (len_r - 6'd1));
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase

      // Packet completion overrides the per-state updates above.
      if (xfer && tx_eop) begin
        pkt_count <= pkt_count + 32'd1;
        seq       <= seq + 16'd1;
        tx_valid  <= 1'b0;
        tx_data   <= '0;
        tx_sop    <= 1'b0;
        tx_eop    <= 1'b0;
        if (GAP_CYCLES > 0) begin
          state   <= ST_GAP;
          gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        end else begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_tx.sv
// Scoreboard bench for pkt_tx: each accepted request queues its expected
// words, and a negedge monitor pops and compares them on every transfer.
module tb_pkt_tx;
  import pkt_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_dest;
  logic [1:0]  req_src;
  logic [5:0]  req_len;
  logic [31:0] timer;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        busy;
  logic [31:0] pkt_count;

  pkt_tx #(.GAP_CYCLES(1), .BLOCK_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_src(req_src), .req_len(req_len),
    .timer(timer),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    timer = timer + 32'd1;
  end

  // kind: 0 fixed word, 1 HDR5 (timer at HDR4 transfer), 2 HDR4, 3 payload
  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    int          kind;
  } word_t;

  word_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          xfer_count = 0;
  logic [15:0] exp_seq = 16'd0;
  logic [31:0] hdr5_exp = 32'd0;
  logic [31:0] last_hdr0, last_hdr4, last_hdr5, last_payload;
  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic        held_s, held_e;

  task automatic push_pkt(input logic [1:0] d, input logic [1:0] s,
                          input logic [5:0] l, input logic [31:0] ts);
    word_t w;
    w = '{pack_hdr0(l, d), 1'b1, 1'b0, 0};      sb.push_back(w);
    w = '{32'h0, 1'b0, 1'b0, 0};                sb.push_back(w);
    w = '{{22'h0, s, 8'h0}, 1'b0, 1'b0, 0};     sb.push_back(w);
    w = '{32'h0, 1'b0, 1'b0, 0};                sb.push_back(w);
    w = '{ts, 1'b0, 1'b0, 2};                   sb.push_back(w);
    w = '{32'h0, 1'b0, (l == 6'd0), 1};         sb.push_back(w);
    for (int i = 0; i < int'(l); i++) begin
      w = '{{exp_seq, 10'h0, 6'(i)}, 1'b0, (i == int'(l) - 1), 3};
      sb.push_back(w);
    end
    exp_seq = exp_seq + 16'd1;
  endtask

  always @(negedge clk) begin
    word_t       e;
    logic [31:0] exp_d;
    if (reset) begin
      sb.delete();
      held_v  = 1'b0;
      exp_seq = 16'd0;
    end else begin
      if (held_v) begin
        checks++;
        if (tx_data !== held_d || tx_sop !== held_s || tx_eop !== held_e) begin
          errors++;
          $display("FAIL stall_hold data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                   tx_data, tx_sop, tx_eop, held_d, held_s, held_e);
        end
      end
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
      held_s = tx_sop;
      held_e = tx_eop;
      if (tx_valid && tx_ready) begin
        xfer_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word data=%h sop=%b eop=%b required no word",
                   tx_data, tx_sop, tx_eop);
        end else begin
          e = sb.pop_front();
          exp_d = (e.kind == 1) ? hdr5_exp : e.data;
          if (e.kind == 2) hdr5_exp = timer;
          if (tx_data !== exp_d || tx_sop !== e.sop || tx_eop !== e.eop) begin
            errors++;
            $display("FAIL stream_word data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                     tx_data, tx_sop, tx_eop, exp_d, e.sop, e.eop);
          end
          if (e.sop)       last_hdr0    = tx_data;
          if (e.kind == 2) last_hdr4    = tx_data;
          if (e.kind == 1) last_hdr5    = tx_data;
          if (e.kind == 3) last_payload = tx_data;
        end
      end
      if (req_valid && req_ready) push_pkt(req_dest, req_src, req_len, timer);
    end
  end

  task automatic send_req(input logic [1:0] d, input logic [1:0] s,
                          input logic [5:0] l, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_dest  = d;
    req_src   = s;
    req_len   = l;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy && !tx_valid && sb.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_valid, req_ready, tx_sop, tx_eop, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl valid/ready/sop/eop/busy=%b required 00000",
               {tx_valid, req_ready, tx_sop, tx_eop, busy});
    end
    checks++;
    if (tx_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h required 0", tx_data);
    end
    checks++;
    if (pkt_count !== 32'h0) begin
      errors++; $display("FAIL reset_count got=%0d required 0", pkt_count);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready got=%b required 1", req_ready);
    end
  endtask

  task automatic test_single;
    bit ok; int base;
    base = xfer_count;
    send_req(2'd2, 2'd1, 6'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept got=timeout required accept"); end
    wait_done(ok);
    checks++;
    if (!ok || xfer_count - base != HDR_WORDS + 3) begin
      errors++; $display("FAIL single_words got=%0d required %0d", xfer_count - base, HDR_WORDS + 3);
    end
    checks++;
    if (last_hdr0 !== 32'h03000200) begin
      errors++; $display("FAIL single_hdr0 got=%h required 03000200", last_hdr0);
    end
    checks++;
    if (last_payload !== 32'h00000002) begin
      errors++; $display("FAIL single_last_payload got=%h required 00000002", last_payload);
    end
    checks++;
    if (pkt_count !== 32'd1) begin
      errors++; $display("FAIL single_count got=%0d required 1", pkt_count);
    end
  endtask

  task automatic test_len0;
    bit ok; int base;
    base = xfer_count;
    send_req(2'd3, 2'd3, 6'd0, ok);
    wait_done(ok);
    checks++;
    if (!ok || xfer_count - base != HDR_WORDS) begin
      errors++; $display("FAIL len0_words got=%0d required %0d", xfer_count - base, HDR_WORDS);
    end
    checks++;
    if (last_hdr0 !== 32'h00000300) begin
      errors++; $display("FAIL len0_hdr0 got=%h required 00000300", last_hdr0);
    end
    checks++;
    if (pkt_count !== 32'd2) begin
      errors++; $display("FAIL len0_count got=%0d required 2", pkt_count);
    end
  endtask

  task automatic test_backpressure;
    bit ok; bit a; bit b; int base;
    a = 1'b0; b = 1'b0;
    base = xfer_count;
    send_req(2'd1, 2'd2, 6'd4, ok);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if ((xfer_count - base == 4 && !a) || (xfer_count - base == 7 && !b)) begin
        if (xfer_count - base == 4) a = 1'b1; else b = 1'b1;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1; tx_ready = 1'b1;
      end
      if (xfer_count - base >= HDR_WORDS + 4) break;
    end
    tx_ready = 1'b1;
    wait_done(ok);
    checks++;
    if (!ok || !a || !b || xfer_count - base != HDR_WORDS + 4) begin
      errors++;
      $display("FAIL bp_words got=%0d stalls=%b%b required %0d stalls=11",
               xfer_count - base, a, b, HDR_WORDS + 4);
    end
    checks++;
    if (pkt_count !== 32'd3) begin
      errors++; $display("FAIL bp_count got=%0d required 3", pkt_count);
    end
  endtask

  task automatic test_timer_wrap;
    bit ok;
    @(posedge clk); #2;
    timer     = 32'hFFFF_FFFE;
    req_dest  = 2'd0;
    req_src   = 2'd1;
    req_len   = 6'd2;
    req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_ready got=%b required 1", req_ready);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || last_hdr4 !== 32'hFFFF_FFFE || last_hdr5 !== 32'h0000_0003) begin
      errors++;
      $display("FAIL wrap_stamps hdr4=%h hdr5=%h required fffffffe 00000003", last_hdr4, last_hdr5);
    end
    checks++;
    if (last_hdr5 - last_hdr4 !== 32'd5) begin
      errors++; $display("FAIL wrap_delta got=%0d required 5", last_hdr5 - last_hdr4);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; int base;
    base = xfer_count;
    send_req(2'd0, 2'd3, 6'd10, ok);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (xfer_count - base >= HDR_WORDS + 5) break;
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({tx_valid, tx_sop, tx_eop, busy, req_ready} !== 5'b0 || tx_data !== 32'h0 ||
        pkt_count !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs valid/sop/eop/busy/ready=%b data=%h count=%0d required 00000 0 0",
               {tx_valid, tx_sop, tx_eop, busy, req_ready}, tx_data, pkt_count);
    end
    @(posedge clk); #1; reset = 1'b0;
    base = xfer_count;
    send_req(2'd1, 2'd0, 6'd2, ok);
    wait_done(ok);
    checks++;
    if (!ok || xfer_count - base != HDR_WORDS + 2 || last_payload !== 32'h00000001) begin
      errors++;
      $display("FAIL midreset_restart words=%0d payload=%h required %0d 00000001",
               xfer_count - base, last_payload, HDR_WORDS + 2);
    end
    checks++;
    if (pkt_count !== 32'd1) begin
      errors++; $display("FAIL midreset_count got=%0d required 1", pkt_count);
    end
  endtask

  task automatic test_back_to_back;
    bit ok; bit found;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    req_dest = 2'd2; req_src = 2'd0; req_len = 6'd2; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    req_dest = 2'd1; req_src = 2'd1; req_len = 6'd3;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && tx_eop) begin found = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!found || tx_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap eop_seen=%b valid=%b ready=%b required 1 0 0", found, tx_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle valid=%b ready=%b required 0 1", tx_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_sop !== 1'b1) begin
      errors++; $display("FAIL b2b_hdr0 valid=%b sop=%b required 1 1", tx_valid, tx_sop);
    end
    wait_done(ok);
    checks++;
    if (!ok || last_payload !== 32'h00010002) begin
      errors++; $display("FAIL b2b_seq got=%h required 00010002", last_payload);
    end
    checks++;
    if (pkt_count !== 32'd2) begin
      errors++; $display("FAIL b2b_count got=%0d required 2", pkt_count);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_dest  = 2'd0;
    req_src   = 2'd0;
    req_len   = 6'd0;
    tx_ready  = 1'b1;
    timer     = 32'd1000;
    test_reset();
    test_single();
    test_len0();
    test_backpressure();
    test_timer_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
